axi_lite_ram_slave: RTL and testbench
=====================================

AXI_LITE_RAM_SLAVE -- requirements
Module: axi_lite_ram_slave

Interface
REQ-001 Parameter DATA_W, default 32, meaning data bus width; only 32 or 64 legal.
REQ-002 Parameter DEPTH, default 16, meaning number of DATA_W-bit words; DEPTH >= 2, power of 2 not required.
REQ-003 Parameter ADDR_W, default 8, meaning byte address width; ADDR_W >= clog2(DEPTH*DATA_W/8).
REQ-004 Ports, listed as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- i_axi_awaddr  in  ADDR_W  write byte address.
- i_axi_awvalid  in  1; o_axi_awready  out  1.
- i_axi_wdata  in  DATA_W; i_axi_wstrb  in  DATA_W/8; i_axi_wvalid  in  1; o_axi_wready  out  1.
- o_axi_bresp  out  2; o_axi_bvalid  out  1; i_axi_bready  in  1.
- i_axi_araddr  in  ADDR_W; i_axi_arvalid  in  1; o_axi_arready  out  1.
- o_axi_rdata  out  DATA_W; o_axi_rresp  out  2; o_axi_rvalid  out  1; i_axi_rready  in  1.

Function
REQ-005 Word index = addr[ADDR_W-1:clog2(DATA_W/8)]; byte-offset bits ignored, no misalignment error.
REQ-006 Index >= DEPTH -> response DECERR (2'b11), no memory write, rdata = 0; otherwise OKAY (2'b00); SLVERR and EXOKAY never issued.
REQ-007 AW, W and AR each have an independent 2-entry FIFO; a handshake occurs when valid && ready.
REQ-008 o_axi_awready, o_axi_wready and o_axi_arready are registered and equal (FIFO count < 2); no combinational path from any input to any ready.
REQ-009 AW and W are accepted independently; W may lead or trail AW by up to 2 beats.
REQ-010 Write commit happens in a cycle where the AW FIFO and W FIFO are both non-empty and (!o_axi_bvalid || i_axi_bready).
REQ-011 On commit, both FIFO heads pop; byte lane k of mem[idx] updates only when wstrb[k]=1; o_axi_bvalid=1 next cycle with bresp per REQ-006.
REQ-012 Read commit happens when the AR FIFO is non-empty and (!o_axi_rvalid || i_axi_rready); the head pops, and o_axi_rvalid=1 next cycle with rdata/rresp.
REQ-013 Minimum latency is 2 cycles from address handshake to response valid (1 cycle FIFO, 1 cycle commit); back-to-back commits sustain 1 transaction per cycle per direction with bready/rready held high.
REQ-014 Read and write committing in the same cycle to the same word: the read returns pre-write data (read-first); the write takes effect for all later reads.
REQ-015 o_axi_bvalid/bresp and o_axi_rvalid/rdata/rresp hold stable while valid && !ready.
REQ-016 A FIFO push and pop in the same cycle leaves the count unchanged; a push when full is impossible (ready low).
REQ-017 Per direction, accepted-minus-responded count never exceeds 3 (2 FIFO + 1 response register); write-data count likewise.
REQ-018 Responses are issued in acceptance order per direction; there is no ordering between read and write responses.
REQ-019 Data-path width follows DATA_W; strobe width is DATA_W/8; no truncation in index compare (compare at ADDR_W width).

Reset
REQ-020 rst_n low asynchronously empties all FIFOs, clears o_axi_bvalid and o_axi_rvalid, and sets all readies to 0; readies become 1 on the first clk edge after rst_n deasserts.
REQ-021 o_axi_bresp, o_axi_rresp and o_axi_rdata reset to 0.
REQ-022 Memory contents are not reset; they are undefined after power-up and retained across rst_n.
REQ-023 Reset mid-transaction discards all in-flight AW/W/AR entries and pending responses with no memory write; no response is issued for them after reset.

Verification
REQ-024 Scenarios:
- DATA_W=32: write addr 0x04, data 0xDEADBEEF, strb 0xF; read 0x04 -> bresp 00, rdata 0xDEADBEEF, rresp 00.
- DATA_W=64: write 0x08 all-ones, then write 0x08 data 0, strb 0x0F; read -> rdata 0xFFFFFFFF_00000000.
- DEPTH=16, DATA_W=32: write and read addr 0x40 -> bresp 11, rresp 11, rdata 0, mem unchanged.
- W beats ahead of AW by 2, bready=0 for 5 cycles -> wready=0 after 2 W beats, one bvalid held stable, then 2 OKAY responses in order.
- Same-cycle read and write commit to word 3: old value 0x11111111, new 0x22222222 -> read returns 0x11111111; next read returns 0x22222222.
- rst_n pulsed with 2 AR pending -> rvalid=0; no R beats after reset; a post-reset read of a pre-reset-written word returns the retained data.

Source files
------------

// File: rtl/axi_lite_ram.sv
// AXI4-Lite slave wrapping a DEPTH-word RAM of DATA_W-bit words.
//
// Ports
//   clk, rst_n                    rising-edge clock, asynchronous active-low reset
//   i_axi_aw*/o_axi_awready       write address channel
//   i_axi_w*/o_axi_wready         write data channel (byte strobes)
//   o_axi_b*/i_axi_bready         write response channel
//   i_axi_ar*/o_axi_arready       read address channel
//   o_axi_r*/i_axi_rready         read data channel
//
// AW, W and AR each sit in their own 2-entry FIFO. A write commits once both
// AW and W heads are present and the B register is free; a read commits once
// the AR head is present and the R register is free. Word indices at or past
// DEPTH answer DECERR, never touch the RAM and read back as zero.
// DATA_W must be 32 or 64.

module axi_lite_ram_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             ready
);
    logic [WIDTH-1:0] slot [0:1];
    logic             rd_ptr;
    logic             wr_ptr;
    logic [1:0]       count;
    logic [1:0]       count_nxt;

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // ready is a flop on the next count, so it never depends on this cycle's inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
            ready  <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count_nxt;
            ready <= (count_nxt != 2'd2);
        end
    end

    always_ff @(posedge clk) begin
        if (push) slot[wr_ptr] <= push_data;
    end

    assign head      = slot[rd_ptr];
    assign not_empty = (count != 2'd0);
endmodule

module axi_lite_ram_slave #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [ADDR_W-1:0]   i_axi_awaddr,
    input  logic                i_axi_awvalid,
    output logic                o_axi_awready,
    input  logic [DATA_W-1:0]   i_axi_wdata,
    input  logic [DATA_W/8-1:0] i_axi_wstrb,
    input  logic                i_axi_wvalid,
    output logic                o_axi_wready,
    output logic [1:0]          o_axi_bresp,
    output logic                o_axi_bvalid,
    input  logic                i_axi_bready,
    input  logic [ADDR_W-1:0]   i_axi_araddr,
    input  logic                i_axi_arvalid,
    output logic                o_axi_arready,
    output logic [DATA_W-1:0]   o_axi_rdata,
    output logic [1:0]          o_axi_rresp,
    output logic                o_axi_rvalid,
    input  logic                i_axi_rready
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A     = ADDR_W'(DEPTH);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_DECERR = 2'b11;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic                     aw_push, w_push, ar_push;
    logic                     aw_ne, w_ne, ar_ne;
    logic                     wr_commit, rd_commit;
    logic [ADDR_W-1:0]        aw_head, ar_head;
    logic [DATA_W+STRB_W-1:0] w_head;
    logic [DATA_W-1:0]        w_data;
    logic [STRB_W-1:0]        w_strb;
    logic [ADDR_W-1:0]        aw_word, ar_word;
    logic [IDX_W-1:0]         aw_idx, ar_idx;
    logic                     aw_ok, ar_ok;

    assign aw_push = i_axi_awvalid && o_axi_awready;
    assign w_push  = i_axi_wvalid  && o_axi_wready;
    assign ar_push = i_axi_arvalid && o_axi_arready;

    assign wr_commit = aw_ne && w_ne && (!o_axi_bvalid || i_axi_bready);
    assign rd_commit = ar_ne && (!o_axi_rvalid || i_axi_rready);

    axi_lite_ram_fifo2 #(.WIDTH(ADDR_W)) u_aw_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (aw_push),
        .push_data (i_axi_awaddr),
        .pop       (wr_commit),
        .head      (aw_head),
        .not_empty (aw_ne),
        .ready     (o_axi_awready)
    );

    axi_lite_ram_fifo2 #(.WIDTH(DATA_W + STRB_W)) u_w_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data ({i_axi_wstrb, i_axi_wdata}),
        .pop       (wr_commit),
        .head      (w_head),
        .not_empty (w_ne),
        .ready     (o_axi_wready)
    );

    axi_lite_ram_fifo2 #(.WIDTH(ADDR_W)) u_ar_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ar_push),
        .push_data (i_axi_araddr),
        .pop       (rd_commit),
        .head      (ar_head),
        .not_empty (ar_ne),
        .ready     (o_axi_arready)
    );

    assign w_data = w_head[DATA_W-1:0];
    assign w_strb = w_head[DATA_W +: STRB_W];

    // Range check uses the full-width word number so out-of-range addresses
    // cannot alias onto low words; the narrow index is only used when in range.
    assign aw_word = aw_head >> OFF_W;
    assign ar_word = ar_head >> OFF_W;
    assign aw_ok   = (aw_word < DEPTH_A);
    assign ar_ok   = (ar_word < DEPTH_A);
    assign aw_idx  = aw_word[IDX_W-1:0];
    assign ar_idx  = ar_word[IDX_W-1:0];

    // RAM is never reset; its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_commit && aw_ok) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (w_strb[k]) mem[aw_idx][8*k +: 8] <= w_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_axi_bvalid <= 1'b0;
            o_axi_bresp  <= 2'b00;
        end else if (wr_commit) begin
            o_axi_bvalid <= 1'b1;
            o_axi_bresp  <= aw_ok ? RESP_OKAY : RESP_DECERR;
        end else if (i_axi_bready) begin
            o_axi_bvalid <= 1'b0;
        end
    end

    // Same-cycle read and write to one word returns the old word: the RAM
    // update lands at the same edge that samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_axi_rvalid <= 1'b0;
            o_axi_rresp  <= 2'b00;
            o_axi_rdata  <= '0;
        end else if (rd_commit) begin
            o_axi_rvalid <= 1'b1;
            o_axi_rresp  <= ar_ok ? RESP_OKAY : RESP_DECERR;
            o_axi_rdata  <= ar_ok ? mem[ar_idx] : '0;
        end else if (i_axi_rready) begin
            o_axi_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_ram_slave.sv
// Self-checking bench for axi_lite_ram_slave: a 32-bit instance under random
// traffic against a word-array reference model with a response scoreboard,
// plus a 64-bit instance for the strobe-merge case.

module tb_axi_lite_ram_slave;
    localparam int DEP = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]  awaddr, araddr;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, arready, bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic [7:0]  awaddr6, araddr6;
    logic        awvalid6, wvalid6, arvalid6, bready6, rready6;
    logic [63:0] wdata6;
    logic [7:0]  wstrb6;
    logic        awready6, wready6, arready6, bvalid6, rvalid6;
    logic [1:0]  bresp6, rresp6;
    logic [63:0] rdata6;

    axi_lite_ram_slave #(.DATA_W(32), .DEPTH(DEP), .ADDR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
        .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .o_axi_wready(wready),
        .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
        .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
        .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid), .i_axi_rready(rready)
    );

    axi_lite_ram_slave #(.DATA_W(64), .DEPTH(DEP), .ADDR_W(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .i_axi_awaddr(awaddr6), .i_axi_awvalid(awvalid6), .o_axi_awready(awready6),
        .i_axi_wdata(wdata6), .i_axi_wstrb(wstrb6), .i_axi_wvalid(wvalid6), .o_axi_wready(wready6),
        .o_axi_bresp(bresp6), .o_axi_bvalid(bvalid6), .i_axi_bready(bready6),
        .i_axi_araddr(araddr6), .i_axi_arvalid(arvalid6), .o_axi_arready(arready6),
        .o_axi_rdata(rdata6), .o_axi_rresp(rresp6), .o_axi_rvalid(rvalid6), .i_axi_rready(rready6)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // stimulus queues and expected-response scoreboard
    logic [7:0]  aw_q[$];
    logic [7:0]  ar_q[$];
    logic [35:0] w_q[$];
    logic [1:0]  exp_b[$];
    logic [33:0] exp_r[$];
    logic [31:0] ref_mem [0:DEP-1];

    bit rand_gap = 1'b1;
    bit rand_bp = 1'b0;
    bit force_b_low = 1'b0;
    bit force_r_low = 1'b0;

    task automatic issue_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                               input bit push_aw, input bit push_w);
        int idx;
        idx = int'(a) / 4;
        if (push_aw) aw_q.push_back(a);
        if (push_w)  w_q.push_back({s, d});
        if (idx < DEP) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b11);
        end
    endtask

    task automatic issue_read(input logic [7:0] a);
        int idx;
        idx = int'(a) / 4;
        ar_q.push_back(a);
        if (idx < DEP) exp_r.push_back({2'b00, ref_mem[idx]});
        else           exp_r.push_back({2'b11, 32'h0});
    endtask

    // channel drivers: ready is registered, so its negedge value holds at the next posedge
    bit aw_fire, w_fire, ar_fire;

    always begin
        @(negedge clk); aw_fire = awvalid && awready && rst_n;
        @(posedge clk); #1;
        if (aw_fire) awvalid = 1'b0;
        if (!awvalid && aw_q.size() != 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            awaddr = aw_q.pop_front(); awvalid = 1'b1;
        end
    end

    always begin
        @(negedge clk); w_fire = wvalid && wready && rst_n;
        @(posedge clk); #1;
        if (w_fire) wvalid = 1'b0;
        if (!wvalid && w_q.size() != 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            {wstrb, wdata} = w_q.pop_front(); wvalid = 1'b1;
        end
    end

    always begin
        @(negedge clk); ar_fire = arvalid && arready && rst_n;
        @(posedge clk); #1;
        if (ar_fire) arvalid = 1'b0;
        if (!arvalid && ar_q.size() != 0 && (!rand_gap || $urandom_range(0, 3) != 0)) begin
            araddr = ar_q.pop_front(); arvalid = 1'b1;
        end
    end

    always begin
        @(posedge clk); #1;
        bready = !force_b_low && (!rand_bp || $urandom_range(0, 2) != 0);
        rready = !force_r_low && (!rand_bp || $urandom_range(0, 2) != 0);
    end

    // monitor
    bit          b_stall = 1'b0, r_stall = 1'b0;
    logic [1:0]  b_prev;
    logic [33:0] r_prev;
    int          r_beats = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            b_stall = 1'b0;
            r_stall = 1'b0;
        end else begin
            if (bvalid) begin
                if (b_stall) check("b_stable", bresp, b_prev);
                if (bready) begin
                    if (exp_b.size() == 0) check("b_unexpected", bvalid, 0);
                    else                   check("bresp", bresp, exp_b.pop_front());
                end
                b_stall = !bready;
                b_prev  = bresp;
            end else begin
                if (b_stall) check("b_dropped", bvalid, 1);
                b_stall = 1'b0;
            end
            if (rvalid) begin
                if (r_stall) check("r_stable", {rresp, rdata}, r_prev);
                if (rready) begin
                    r_beats++;
                    if (exp_r.size() == 0) check("r_unexpected", rvalid, 0);
                    else                   check("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
                end
                r_stall = !rready;
                r_prev  = {rresp, rdata};
            end else begin
                if (r_stall) check("r_dropped", rvalid, 1);
                r_stall = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        int t;
        t = 0;
        while (t < 3000 && !(aw_q.size() == 0 && w_q.size() == 0 && ar_q.size() == 0 &&
                             !awvalid && !wvalid && !arvalid &&
                             exp_b.size() == 0 && exp_r.size() == 0)) begin
            @(negedge clk); t++;
        end
        if (t >= 3000) begin
            n_cmp++; n_bad++;
            $display("FAIL idle_timeout: got %0d pending B, %0d pending R, required 0",
                     exp_b.size(), exp_r.size());
            aw_q.delete(); w_q.delete(); ar_q.delete(); exp_b.delete(); exp_r.delete();
        end
        @(negedge clk);
    endtask

    task automatic wr64(input logic [7:0] a, input logic [63:0] d, input logic [7:0] s);
        int t;
        awaddr6 = a; wdata6 = d; wstrb6 = s; awvalid6 = 1'b1; wvalid6 = 1'b1;
        t = 0;
        while (!(awready6 && wready6) && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        awvalid6 = 1'b0; wvalid6 = 1'b0;
        t = 0;
        while (!bvalid6 && t < 100) begin @(negedge clk); t++; end
        check("bresp64", {bvalid6, bresp6}, {1'b1, 2'b00});
        @(negedge clk);
    endtask

    task automatic rd64(input logic [7:0] a, input logic [63:0] exp);
        int t;
        araddr6 = a; arvalid6 = 1'b1;
        t = 0;
        while (!arready6 && t < 100) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        arvalid6 = 1'b0;
        t = 0;
        while (!rvalid6 && t < 100) begin @(negedge clk); t++; end
        check("rdata64", {rvalid6, rresp6, rdata6}, {1'b1, 2'b00, exp});
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int beats0;
        rst_n = 1'b0;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
        bready = 1'b1; rready = 1'b1;
        awvalid6 = 1'b0; wvalid6 = 1'b0; arvalid6 = 1'b0;
        awaddr6 = '0; araddr6 = '0; wdata6 = '0; wstrb6 = '0;
        bready6 = 1'b1; rready6 = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_readies", {awready, wready, arready, awready6}, 4'b0000);
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_resp_data", {bresp, rresp, rdata}, 36'h0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", {awready, wready, arready}, 3'b000);
        @(negedge clk);
        check("ready_after_edge", {awready, wready, arready}, 3'b111);

        // give every word a known value under random gaps and back-pressure
        rand_gap = 1'b1; rand_bp = 1'b1;
        for (int i = 0; i < DEP; i++) issue_write(8'(i * 4), $urandom, 4'hF, 1'b1, 1'b1);
        wait_idle();

        issue_write(8'h04, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1);
        wait_idle();
        issue_read(8'h04);
        wait_idle();

        // out of range: DECERR, zero data, RAM untouched (word 0 reread)
        issue_write(8'h40, $urandom, 4'hF, 1'b1, 1'b1);
        wait_idle();
        issue_read(8'h40);
        issue_read(8'h00);
        wait_idle();

        for (int b = 0; b < 25; b++) begin
            int nw, nr;
            nw = $urandom_range(1, 6);
            nr = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++)
                issue_write(8'($urandom_range(0, 79)), $urandom, 4'($urandom_range(0, 15)), 1'b1, 1'b1);
            wait_idle();
            for (int i = 0; i < nr; i++) issue_read(8'($urandom_range(0, 79)));
            wait_idle();
        end

        // W leads AW by two beats while B is stalled
        rand_gap = 1'b0; rand_bp = 1'b0; force_b_low = 1'b1;
        issue_write(8'h14, 32'hA5A5_0001, 4'hF, 1'b0, 1'b1);
        issue_write(8'h18, 32'hA5A5_0002, 4'hF, 1'b0, 1'b1);
        t = 0;
        while (!(w_q.size() == 0 && !wvalid) && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        check("wready_full", {wready, awready}, 2'b01);
        aw_q.push_back(8'h14);
        aw_q.push_back(8'h18);
        t = 0;
        while (!bvalid && t < 100) begin @(negedge clk); t++; end
        repeat (5) begin
            @(negedge clk);
            check("bvalid_held", bvalid, 1);
        end
        force_b_low = 1'b0;
        wait_idle();
        issue_read(8'h14);
        issue_read(8'h18);
        wait_idle();

        // read and write to word 3 committing in the same cycle
        issue_write(8'h0C, 32'h11111111, 4'hF, 1'b1, 1'b1);
        wait_idle();
        ar_q.push_back(8'h0C);
        exp_r.push_back({2'b00, 32'h11111111});
        issue_write(8'h0C, 32'h22222222, 4'hF, 1'b1, 1'b1);
        wait_idle();
        issue_read(8'h0C);
        wait_idle();

        // reset with reads stuck behind a stalled R channel
        force_r_low = 1'b1;
        issue_read(8'h0C);
        issue_read(8'h10);
        issue_read(8'h14);
        t = 0;
        while (!(ar_q.size() == 0 && !arvalid) && t < 100) begin @(negedge clk); t++; end
        repeat (2) @(negedge clk);
        check("pre_reset_pending", {rvalid, arready}, 2'b10);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        check("reset_clears", {rvalid, bvalid, awready, wready, arready}, 5'b00000);
        exp_r.delete();
        exp_b.delete();
        force_r_low = 1'b0;
        @(posedge clk); #3 rst_n = 1'b1;
        beats0 = r_beats;
        repeat (10) @(negedge clk);
        check("r_beats_after_reset", r_beats - beats0, 0);
        issue_read(8'h0C);
        wait_idle();

        // 64-bit data path with partial strobes
        @(negedge clk);
        wr64(8'h08, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        wr64(8'h08, 64'h0, 8'h0F);
        rd64(8'h08, 64'hFFFF_FFFF_0000_0000);

        check("b_left", exp_b.size(), 0);
        check("r_left", exp_r.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
